// File: rtl/jtcontra_vout.sv
// jtcontra_vout: colour expansion, blanking, pause fade/dim and sync alignment; optional scanlines via JTCONTRA_SCANLINES_EN
module jtcontra_vout #(
  parameter int FADE_FRAMES = 4
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       pxl_cen,
  input  logic       LHBL_dly,
  input  logic       LVBL_dly,
  input  logic       HS,
  input  logic       VS,
  input  logic [4:0] red,
  input  logic [4:0] green,
  input  logic [4:0] blue,
  input  logic       dip_pause,
  output logic [7:0] vo_red,
  output logic [7:0] vo_green,
  output logic [7:0] vo_blue,
  output logic       vo_LHBL,
  output logic       vo_LVBL,
  output logic       vo_HS,
  output logic       vo_VS,
  output logic       dimmed
);
  typedef enum logic [1:0] {RUN, FADE_OUT, DIM, FADE_IN} state_t;
  state_t      state_q;
  logic [1:0]  lvl_q;
  logic [3:0]  cnt_q;
  logic        lvbl_last_q;
  logic [7:0]  r1_q, g1_q, b1_q;
  logic [3:0]  s1_q;
  logic        odd_q;
  logic        frame_tick, blank, done;
  logic [3:0]  cnt_nx;

  assign frame_tick = lvbl_last_q & ~LVBL_dly;
  assign blank      = ~LHBL_dly | ~LVBL_dly;
  assign cnt_nx     = cnt_q + 4'd1;
  assign done       = cnt_nx == 4'(FADE_FRAMES);

  function automatic logic [7:0] expand(input logic [4:0] c, input logic b);
    return b ? 8'd0 : {c, c[4:2]};
  endfunction

  // lvl 3 never occurs but shares the lvl 2 halving path
  function automatic logic [7:0] shade(input logic [7:0] c, input logic [1:0] l, input logic o);
    logic [7:0] d;
    d = l[1] ? c >> 1 : l[0] ? c - (c >> 2) : c;
    return o ? d - (d >> 2) : d;
  endfunction

`ifdef JTCONTRA_SCANLINES_EN
  logic lhbl_last_q;
  // line parity: toggles at each line blank start, restarts even at the frame tick
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lhbl_last_q <= 1'b0;
      odd_q       <= 1'b0;
    end else if (pxl_cen) begin
      lhbl_last_q <= LHBL_dly;
      odd_q       <= frame_tick ? 1'b0 : (lhbl_last_q & ~LHBL_dly) ? ~odd_q : odd_q;
    end
`else
  assign odd_q = 1'b0;
`endif

  // pause fade FSM; lvl only moves on frame ticks, which fall inside vertical blanking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= RUN;
      lvl_q       <= 2'd0;
      cnt_q       <= 4'd0;
      lvbl_last_q <= 1'b0;
    end else if (pxl_cen) begin
      lvbl_last_q <= LVBL_dly;
      if (frame_tick)
        case (state_q)
          RUN: if (!dip_pause) begin
            state_q <= FADE_OUT;
            cnt_q   <= 4'd0;
          end
          FADE_OUT: if (dip_pause) begin
            state_q <= FADE_IN;
            cnt_q   <= 4'd0;
          end else if (done) begin
            lvl_q   <= lvl_q == 2'd0 ? 2'd1 : 2'd2;
            state_q <= lvl_q == 2'd0 ? FADE_OUT : DIM;
            cnt_q   <= 4'd0;
          end else cnt_q <= cnt_nx;
          DIM: if (dip_pause) begin
            state_q <= FADE_IN;
            cnt_q   <= 4'd0;
          end
          default: if (!dip_pause) begin
            state_q <= FADE_OUT;
            cnt_q   <= 4'd0;
          end else if (done) begin
            lvl_q   <= lvl_q[1] ? 2'd1 : 2'd0;
            state_q <= lvl_q[1] ? FADE_IN : RUN;
            cnt_q   <= 4'd0;
          end else cnt_q <= cnt_nx;
        endcase
    end

  // two-stage colour pipeline with syncs delayed alongside
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r1_q     <= 8'd0;
      g1_q     <= 8'd0;
      b1_q     <= 8'd0;
      s1_q     <= 4'd0;
      vo_red   <= 8'd0;
      vo_green <= 8'd0;
      vo_blue  <= 8'd0;
      {vo_LHBL, vo_LVBL, vo_HS, vo_VS} <= 4'd0;
      dimmed   <= 1'b0;
    end else if (pxl_cen) begin
      r1_q     <= expand(red, blank);
      g1_q     <= expand(green, blank);
      b1_q     <= expand(blue, blank);
      s1_q     <= {LHBL_dly, LVBL_dly, HS, VS};
      vo_red   <= shade(r1_q, lvl_q, odd_q);
      vo_green <= shade(g1_q, lvl_q, odd_q);
      vo_blue  <= shade(b1_q, lvl_q, odd_q);
      {vo_LHBL, vo_LVBL, vo_HS, vo_VS} <= s1_q;
      dimmed   <= lvl_q[1];
    end
endmodule

// File: tb/tb_jtcontra_vout.sv
// tb_jtcontra_vout: table-driven colour vectors plus fade, reversal and reset sequences
module tb_jtcontra_vout;
  logic       rst, clk, pxl_cen, LHBL_dly, LVBL_dly, HS, VS, dip_pause;
  logic [4:0] red, green, blue;
  logic [7:0] vo_red, vo_green, vo_blue;
  logic       vo_LHBL, vo_LVBL, vo_HS, vo_VS, dimmed;
  int         ncmp = 0, nerr = 0;

  jtcontra_vout #(.FADE_FRAMES(4)) dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
    .HS(HS), .VS(VS), .red(red), .green(green), .blue(blue), .dip_pause(dip_pause),
    .vo_red(vo_red), .vo_green(vo_green), .vo_blue(vo_blue), .vo_LHBL(vo_LHBL),
    .vo_LVBL(vo_LVBL), .vo_HS(vo_HS), .vo_VS(vo_VS), .dimmed(dimmed)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] r, g, b;
    logic       lh, lv, hs, vs;
    logic [7:0] er, eg, eb;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    pxl_cen = 1;
    @(posedge clk);
    #1 pxl_cen = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    LVBL_dly = 0;
    tick();
    tick();
    LVBL_dly = 1;
    tick();
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    vecs[0] = '{5'h1F, 5'h10, 5'h00, 1, 1, 0, 0, 8'hFF, 8'h84, 8'h00};
    vecs[1] = '{5'h00, 5'h1F, 5'h01, 1, 1, 1, 0, 8'h00, 8'hFF, 8'h08};
    vecs[2] = '{5'h15, 5'h0A, 5'h05, 1, 1, 0, 1, 8'hAD, 8'h52, 8'h29};
    vecs[3] = '{5'h1F, 5'h1F, 5'h1F, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{5'h0F, 5'h1E, 5'h11, 1, 1, 0, 0, 8'h7B, 8'hF7, 8'h8C};
    vecs[5] = '{5'h1F, 5'h1F, 5'h1F, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{5'h1F, 5'h10, 5'h00, 1, 1, 0, 0, 8'hFF, 8'h84, 8'h00};
    rst = 1; pxl_cen = 0; LHBL_dly = 1; LVBL_dly = 1; HS = 1; VS = 1;
    red = 5'h1F; green = 5'h1F; blue = 5'h1F; dip_pause = 1;
    repeat (3) @(posedge clk);
    pxl_cen = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_red", vo_red, 0);
    chk("rst_syncs", {vo_LHBL, vo_LVBL, vo_HS, vo_VS}, 0);
    chk("rst_dimmed", dimmed, 0);
    pxl_cen = 0;
    rst = 0;
    for (int i = 0; i < 7; i++) begin
      {red, green, blue} = {vecs[i].r, vecs[i].g, vecs[i].b};
      {LHBL_dly, LVBL_dly, HS, VS} = {vecs[i].lh, vecs[i].lv, vecs[i].hs, vecs[i].vs};
      tick();
      tick();
      chk($sformatf("vec%0d_rgb", i), {vo_red, vo_green, vo_blue}, {vecs[i].er, vecs[i].eg, vecs[i].eb});
      chk($sformatf("vec%0d_sync", i), {vo_LHBL, vo_LVBL, vo_HS, vo_VS},
          {vecs[i].lh, vecs[i].lv, vecs[i].hs, vecs[i].vs});
    end
    // latency: a single-tick pixel and HS pulse appear exactly two ticks later
    red = 5'h00; HS = 0;
    tick(); tick();
    red = 5'h1F; HS = 1;
    tick();
    red = 5'h00; HS = 0;
    chk("lat1_red", vo_red, 8'h00);
    chk("lat1_hs", vo_HS, 0);
    tick();
    chk("lat2_red", vo_red, 8'hFF);
    chk("lat2_hs", vo_HS, 1);
    tick();
    chk("lat3_red", vo_red, 8'h00);
    // nothing moves without pxl_cen
    red = 5'h1F;
    repeat (6) @(posedge clk);
    #1 chk("cen_hold", vo_red, 8'h00);
    tick(); tick();
    chk("cen_go", vo_red, 8'hFF);
    // full fade out and back
    dip_pause = 0; green = 0; blue = 0;
    for (int k = 0; k < 10; k++) begin
      frame();
      chk($sformatf("fade%0d_red", k), vo_red, k < 4 ? 8'hFF : k < 8 ? 8'hC0 : 8'h7F);
      chk($sformatf("fade%0d_dim", k), dimmed, k >= 8);
    end
    dip_pause = 1;
    for (int k = 0; k < 5; k++) begin
      frame();
      chk($sformatf("unfade%0d_red", k), vo_red, k < 4 ? 8'h7F : 8'hC0);
    end
    // reversal at lvl1
    do_reset();
    tick();
    dip_pause = 0;
    for (int k = 0; k < 5; k++) frame();
    chk("rev_lvl1", vo_red, 8'hC0);
    dip_pause = 1;
    for (int k = 0; k < 5; k++) begin
      frame();
      chk($sformatf("rev%0d_red", k), vo_red, k < 4 ? 8'hC0 : 8'hFF);
    end
    frame();
    chk("rev_run_red", vo_red, 8'hFF);
    chk("rev_run_dim", dimmed, 0);
    // asynchronous reset mid-fade
    dip_pause = 0;
    for (int k = 0; k < 5; k++) frame();
    chk("pre_rst_red", vo_red, 8'hC0);
    #2 rst = 1;
    #1 chk("async_rst_red", vo_red, 8'h00);
    chk("async_rst_lhbl", vo_LHBL, 0);
    @(posedge clk);
    #1 rst = 0;
    dip_pause = 1;
    tick();
    chk("post_rst1_red", vo_red, 8'h00);
    tick();
    chk("post_rst2_red", vo_red, 8'hFF);
    chk("post_rst2_dim", dimmed, 0);
    frame();
    chk("post_rst_frame", vo_red, 8'hFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
